// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider: divided clock, aligned tick strobe,
// valid/ready ratio reprogramming applied only at output period boundaries.
module clk_div_ctrl #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DIV_RESET = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] div_active
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic             legal;
  logic             boundary;

  // State and datapath registers; reset discards any pending ratio.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= CNT_W'(DIV_RESET);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state logic; clk_out/tick derive from next-state counter and ratio.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    accept   = cfg_valid && ready_q;
    legal    = (cfg_div >= CNT_W'(2));
    boundary = (state_q == RUN) && (cnt_q == (div_q - CNT_W'(1)));

    if (accept && !legal) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A ratio left pending by a stop at the boundary is applied here.
        if (pend_q) begin
          div_d  = pend_div_q;
          pend_d = 1'b0;
          done_d = 1'b1;
        end else if (accept && legal) begin
          div_d  = cfg_div;
          done_d = 1'b1;
        end
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (boundary) begin
          cnt_d = '0;
          if (pend_q) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
            done_d = 1'b1;
          end
          if (!en) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Accepted after the pending check, so a ratio taken on a
        // boundary edge waits for the following boundary.
        if (accept && legal) begin
          pend_d     = 1'b1;
          pend_div_d = cfg_div;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    clk_out_d = (state_d == RUN) && (cnt_d < (div_d >> 1));
    tick_d    = (state_d == RUN) && (cnt_d == (div_d - CNT_W'(1)));
    ready_d   = !pend_d;
  end

  assign cfg_ready  = ready_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;
  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign running    = (state_q == RUN);
  assign div_active = div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: driver pushes hand-computed per-cycle
// expectations, monitor pops and compares on each falling edge.
module tb_clk_div_ctrl;

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [7:0]       tag;
    logic             co;
    logic             tk;
    logic             rn;
    logic             rdy;
    logic             dn;
    logic             er;
    logic [CNT_W-1:0] da;
  } exp_t;

  logic             clk_in;
  logic             reset_n;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_done;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             running;
  logic [CNT_W-1:0] div_active;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  logic [7:0] cur_tag;

  clk_div_ctrl #(.CNT_W(CNT_W), .DIV_RESET(4)) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .tick       (tick),
    .running    (running),
    .div_active (div_active)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Push one expectation for the current cycle without a clock edge.
  task automatic push(input logic co, input logic tk, input logic rn,
                      input logic rdy, input logic dn, input logic er,
                      input logic [CNT_W-1:0] da);
    exp_t e;
    e.tag = cur_tag; e.co = co; e.tk = tk; e.rn = rn;
    e.rdy = rdy; e.dn = dn; e.er = er; e.da = da;
    exp_q.push_back(e);
  endtask

  // Drive inputs, take one rising edge, then queue the post-edge expectation.
  task automatic step(input logic e_i, input logic v_i, input logic [CNT_W-1:0] d_i,
                      input logic co, input logic tk, input logic rn,
                      input logic rdy, input logic dn, input logic er,
                      input logic [CNT_W-1:0] da);
    en        = e_i;
    cfg_valid = v_i;
    cfg_div   = d_i;
    @(posedge clk_in);
    #1;
    push(co, tk, rn, rdy, dn, er, da);
  endtask

  // Monitor: compare every queued expectation against the DUT outputs.
  initial begin
    vectors     = 0;
    miscompares = 0;
    forever begin
      @(negedge clk_in);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if ({clk_out, tick, running, cfg_ready, cfg_done, cfg_err, div_active} !==
            {e.co, e.tk, e.rn, e.rdy, e.dn, e.er, e.da}) begin
          miscompares++;
          $display("FAIL t%0d vec%0d: got co=%b tk=%b rn=%b rdy=%b dn=%b er=%b da=%0d, exp co=%b tk=%b rn=%b rdy=%b dn=%b er=%b da=%0d",
                   e.tag, vectors, clk_out, tick, running, cfg_ready, cfg_done, cfg_err, div_active,
                   e.co, e.tk, e.rn, e.rdy, e.dn, e.er, e.da);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cur_tag   = 8'd0;
    #1;
    push(0, 0, 0, 1, 0, 0, 8'd4);
    #11;
    reset_n = 1'b1;

    // 1: default ratio 4 -> 1,1,0,0 with tick at cnt=3
    cur_tag = 8'd1;
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 0, 1, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 0, 1, 1, 1, 0, 0, 8'd4);

    // 2: ratio 6 requested at cnt=1, applied at the boundary
    cur_tag = 8'd2;
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd4);
    step(1, 1, 6, 0, 0, 1, 0, 0, 0, 8'd4);
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, 8'd4);
    step(1, 0, 0, 1, 0, 1, 1, 1, 0, 8'd6);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd6);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd6);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd6);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd6);
    step(1, 0, 0, 0, 1, 1, 1, 0, 0, 8'd6);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd6);

    // 3a: illegal ratios while running
    cur_tag = 8'd3;
    step(1, 1, 1, 1, 0, 1, 1, 0, 1, 8'd6);
    step(1, 1, 0, 1, 0, 1, 1, 0, 1, 8'd6);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd6);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd6);
    step(1, 0, 0, 0, 1, 1, 1, 0, 0, 8'd6);

    // 5a: en dropped at cnt=1, period completes then IDLE
    cur_tag = 8'd5;
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd6);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd6);
    step(0, 0, 0, 1, 0, 1, 1, 0, 0, 8'd6);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 8'd6);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 8'd6);
    step(0, 0, 0, 0, 1, 1, 1, 0, 0, 8'd6);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd6);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd6);

    // 3b: illegal ratios in IDLE
    cur_tag = 8'd3;
    step(0, 1, 1, 0, 0, 0, 1, 0, 1, 8'd6);
    step(0, 1, 0, 0, 0, 0, 1, 0, 1, 8'd6);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd6);

    // 4a: program 5 in IDLE then run -> 2 high, 3 low
    cur_tag = 8'd4;
    step(0, 1, 5, 0, 0, 0, 1, 1, 0, 8'd5);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd5);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd5);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd5);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd5);
    step(1, 0, 0, 0, 1, 1, 1, 0, 0, 8'd5);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd5);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd5);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd5);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd5);
    step(1, 0, 0, 0, 1, 1, 1, 0, 0, 8'd5);

    // 4b: ratio 4 accepted on the boundary edge, applied one period later
    step(1, 1, 4, 1, 0, 1, 0, 0, 0, 8'd5);
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, 8'd5);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 8'd5);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 8'd5);
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, 8'd5);
    step(1, 0, 0, 1, 0, 1, 1, 1, 0, 8'd4);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 0, 1, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd4);

    // 5b: pending ratio 3 plus en=0 at the same boundary
    cur_tag = 8'd5;
    step(1, 1, 3, 1, 0, 1, 0, 0, 0, 8'd4);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 8'd4);
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, 8'd4);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 8'd3);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd3);

    // 6: reset mid-high-phase at D=6 with a ratio pending
    cur_tag = 8'd6;
    step(0, 1, 6, 0, 0, 0, 1, 1, 0, 8'd6);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd6);
    step(1, 1, 7, 1, 0, 1, 0, 0, 0, 8'd6);
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, 8'd6);
    #5;
    reset_n = 1'b0;
    en      = 1'b0;
    push(0, 0, 0, 1, 0, 0, 8'd4);
    @(negedge clk_in);
    #2;
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd4);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 0, 1, 1, 1, 0, 0, 8'd4);
    step(1, 0, 0, 1, 0, 1, 1, 0, 0, 8'd4);

    repeat (2) @(negedge clk_in);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
